// File: rtl/sd_cmd_phy_if.sv
// SD CMD-line PHY bus bundle: command-issue handshake, pin signals and status.
interface sd_cmd_phy_if;
  logic        bit_strobe;
  logic        new_command;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_argument;
  logic        resp_expected;
  logic        CMD_PIN_IN;
  logic        CMD_PIN_OUT;
  logic        io_enable_cmd;
  logic        busy;
  logic        cmd_complete;
  logic [5:0]  resp_index;
  logic [31:0] resp_payload;
  logic        timeout_error;
  logic        crc_error;
  logic        index_error;

  // host side: command issue logic plus the pad model
  modport master (
    output bit_strobe, new_command, cmd_index, cmd_argument, resp_expected, CMD_PIN_IN,
    input  CMD_PIN_OUT, io_enable_cmd, busy, cmd_complete, resp_index, resp_payload,
           timeout_error, crc_error, index_error
  );

  // PHY side
  modport slave (
    input  bit_strobe, new_command, cmd_index, cmd_argument, resp_expected, CMD_PIN_IN,
    output CMD_PIN_OUT, io_enable_cmd, busy, cmd_complete, resp_index, resp_payload,
           timeout_error, crc_error, index_error
  );
endinterface

// File: rtl/sd_cmd_phy.sv
// SD command-line PHY: shifts out a 48-bit command frame with CRC7, releases
// the line, optionally captures a 48-bit response and reports status.
module sd_cmd_phy #(
  parameter int RESP_TIMEOUT = 64
) (
  input  logic         clk_host,
  input  logic         reset_host,
  sd_cmd_phy_if.slave  bus
);

  localparam int TW = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(RESP_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_RESP, RECV, CHECK, DONE} state_t;

  state_t        state, state_d;
  logic [47:0]   frame, frame_d;     // current TX bit always sits in [47]
  logic [47:0]   rx, rx_d;
  logic [5:0]    bit_cnt, bit_cnt_d;
  logic [TW-1:0] to_cnt, to_cnt_d;
  logic [5:0]    idx_q, idx_d;
  logic          resp_exp_q, resp_exp_d;
  logic          pin_q, pin_d;
  logic          oe_q, oe_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [5:0]    resp_index_q, resp_index_d;
  logic [31:0]   resp_payload_q, resp_payload_d;
  logic          to_err_q, to_err_d;
  logic          crc_err_q, crc_err_d;
  logic          idx_err_q, idx_err_d;
  logic [6:0]    tx_crc, rx_crc;

  // Serial CRC7 (x^7 + x^3 + 1), MSB first, zero init.
  function automatic logic [6:0] crc7_calc(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  assign tx_crc = crc7_calc({2'b01, bus.cmd_index, bus.cmd_argument});
  assign rx_crc = crc7_calc(rx[47:8]);

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d        = state;
    frame_d        = frame;
    rx_d           = rx;
    bit_cnt_d      = bit_cnt;
    to_cnt_d       = to_cnt;
    idx_d          = idx_q;
    resp_exp_d     = resp_exp_q;
    pin_d          = pin_q;
    oe_d           = oe_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    resp_index_d   = resp_index_q;
    resp_payload_d = resp_payload_q;
    to_err_d       = to_err_q;
    crc_err_d      = crc_err_q;
    idx_err_d      = idx_err_q;
    case (state)
      IDLE: begin
        if (bus.new_command) begin
          frame_d        = {2'b01, bus.cmd_index, bus.cmd_argument, tx_crc, 1'b1};
          idx_d          = bus.cmd_index;
          resp_exp_d     = bus.resp_expected;
          resp_index_d   = '0;
          resp_payload_d = '0;
          to_err_d       = 1'b0;
          crc_err_d      = 1'b0;
          idx_err_d      = 1'b0;
          bit_cnt_d      = '0;
          busy_d         = 1'b1;
          oe_d           = 1'b1;
          pin_d          = 1'b0;
          state_d        = SEND;
        end
      end
      SEND: begin
        if (bus.bit_strobe) begin
          if (bit_cnt == 6'd47) begin
            // end-bit period closed: release the line
            oe_d     = 1'b0;
            pin_d    = 1'b1;
            to_cnt_d = '0;
            if (resp_exp_q) begin
              state_d = WAIT_RESP;
            end else begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt + 6'd1;
            frame_d   = {frame[46:0], 1'b0};
            pin_d     = frame[46];
          end
        end
      end
      WAIT_RESP: begin
        if (bus.bit_strobe) begin
          if (!bus.CMD_PIN_IN) begin
            // start bit lands in rx[47] after the remaining 47 shifts
            rx_d      = '0;
            bit_cnt_d = '0;
            state_d   = RECV;
          end else if (to_cnt == TO_LAST) begin
            to_err_d = 1'b1;
            state_d  = DONE;
            done_d   = 1'b1;
          end else begin
            to_cnt_d = to_cnt + 1'b1;
          end
        end
      end
      RECV: begin
        if (bus.bit_strobe) begin
          rx_d = {rx[46:0], bus.CMD_PIN_IN};
          if (bit_cnt == 6'd46) state_d = CHECK;
          else                  bit_cnt_d = bit_cnt + 6'd1;
        end
      end
      CHECK: begin
        crc_err_d      = rx[46] | (rx_crc != rx[7:1]) | ~rx[0];
        idx_err_d      = (rx[45:40] != idx_q);
        resp_index_d   = rx[45:40];
        resp_payload_d = rx[39:8];
        state_d        = DONE;
        done_d         = 1'b1;
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_host) begin
    if (reset_host) begin
      state          <= IDLE;
      frame          <= '0;
      rx             <= '0;
      bit_cnt        <= '0;
      to_cnt         <= '0;
      idx_q          <= '0;
      resp_exp_q     <= 1'b0;
      pin_q          <= 1'b1;
      oe_q           <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      resp_index_q   <= '0;
      resp_payload_q <= '0;
      to_err_q       <= 1'b0;
      crc_err_q      <= 1'b0;
      idx_err_q      <= 1'b0;
    end else begin
      state          <= state_d;
      frame          <= frame_d;
      rx             <= rx_d;
      bit_cnt        <= bit_cnt_d;
      to_cnt         <= to_cnt_d;
      idx_q          <= idx_d;
      resp_exp_q     <= resp_exp_d;
      pin_q          <= pin_d;
      oe_q           <= oe_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      resp_index_q   <= resp_index_d;
      resp_payload_q <= resp_payload_d;
      to_err_q       <= to_err_d;
      crc_err_q      <= crc_err_d;
      idx_err_q      <= idx_err_d;
    end
  end

  assign bus.CMD_PIN_OUT   = pin_q;
  assign bus.io_enable_cmd = oe_q;
  assign bus.busy          = busy_q;
  assign bus.cmd_complete  = done_q;
  assign bus.resp_index    = resp_index_q;
  assign bus.resp_payload  = resp_payload_q;
  assign bus.timeout_error = to_err_q;
  assign bus.crc_error     = crc_err_q;
  assign bus.index_error   = idx_err_q;

endmodule

// File: tb/tb_sd_cmd_phy.sv
// Directed bench for sd_cmd_phy: TX frames, response checking, timeout,
// strobe stalls, ignored new_command and mid-frame reset.
module tb_sd_cmd_phy;
  logic clk_host = 1'b0;
  logic reset_host = 1'b1;
  int   n_cmp = 0;
  int   n_mis = 0;
  int   div = 1;
  int   phase = 0;

  sd_cmd_phy_if bus ();

  sd_cmd_phy #(.RESP_TIMEOUT(64)) dut (
    .clk_host   (clk_host),
    .reset_host (reset_host),
    .bus        (bus)
  );

  always #5 clk_host = ~clk_host;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // advance one clock, land 1 time unit after the edge, update strobe
  task automatic tick();
    @(posedge clk_host);
    #1;
    phase = (phase + 1) % div;
    bus.bit_strobe = (phase == 0);
  endtask

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  // issue a command (strobe tied high), capture the 48 TX bits
  task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic re,
                          output logic [47:0] fr, output int oe_bad);
    int g;
    g = 0;
    while (bus.busy && g < 20) begin tick(); g++; end
    bus.new_command   = 1'b1;
    bus.cmd_index     = idx;
    bus.cmd_argument  = arg;
    bus.resp_expected = re;
    tick();
    bus.new_command = 1'b0;
    check("busy_at_T1", bus.busy, 1);
    fr = '0;
    oe_bad = 0;
    for (int i = 0; i < 48; i++) begin
      fr = {fr[46:0], bus.CMD_PIN_OUT};
      if (!bus.io_enable_cmd) oe_bad++;
      tick();
    end
  endtask

  task automatic reply(input logic [47:0] r);
    for (int i = 0; i < 5; i++) begin bus.CMD_PIN_IN = 1'b1; tick(); end
    for (int i = 47; i >= 0; i--) begin bus.CMD_PIN_IN = r[i]; tick(); end
    bus.CMD_PIN_IN = 1'b1;
  endtask

  task automatic wait_complete(output int n);
    n = 0;
    while (!bus.cmd_complete && n < 200) begin tick(); n++; end
    check("complete_seen", bus.cmd_complete, 1);
  endtask

  initial begin
    logic [47:0] fr;
    logic [47:0] r;
    logic [19:0] got;
    int oe_bad, n, hold, hold_bad, bits, guard, pulses;

    bus.bit_strobe    = 1'b1;
    bus.new_command   = 1'b0;
    bus.cmd_index     = '0;
    bus.cmd_argument  = '0;
    bus.resp_expected = 1'b0;
    bus.CMD_PIN_IN    = 1'b1;
    tick(); tick();
    reset_host = 1'b0;

    // reset state
    check("rst_pin", bus.CMD_PIN_OUT, 1);
    check("rst_oe", bus.io_enable_cmd, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_complete", bus.cmd_complete, 0);
    check("rst_errs", {bus.timeout_error, bus.crc_error, bus.index_error}, 0);
    check("rst_resp", {bus.resp_index, bus.resp_payload}, 0);

    // CMD0, no response
    send_cmd(6'd0, 32'h0, 1'b0, fr, oe_bad);
    check("cmd0_frame", fr, 48'h400000000095);
    check("cmd0_oe_tx", oe_bad, 0);
    check("cmd0_complete_T49", bus.cmd_complete, 1);
    check("cmd0_oe_rel", bus.io_enable_cmd, 0);
    check("cmd0_pin_rel", bus.CMD_PIN_OUT, 1);
    check("cmd0_errs", {bus.timeout_error, bus.crc_error, bus.index_error}, 0);
    tick();
    check("cmd0_complete_pulse", bus.cmd_complete, 0);
    check("cmd0_busy_fall", bus.busy, 0);

    // CMD8 good reply
    send_cmd(6'd8, 32'h000001AA, 1'b1, fr, oe_bad);
    check("cmd8_frame", fr, 48'h48000001AA87);
    check("cmd8_wait_oe", bus.io_enable_cmd, 0);
    check("cmd8_wait_busy", bus.busy, 1);
    r = 48'h08000001AA13;
    reply(r);
    wait_complete(n);
    check("cmd8_idx", bus.resp_index, 8);
    check("cmd8_payload", bus.resp_payload, 32'h000001AA);
    check("cmd8_errs", {bus.timeout_error, bus.crc_error, bus.index_error}, 0);
    tick();

    // CMD8 bad CRC byte
    send_cmd(6'd8, 32'h000001AA, 1'b1, fr, oe_bad);
    r = 48'h08000001AA15;
    reply(r);
    wait_complete(n);
    check("badcrc_crc", bus.crc_error, 1);
    check("badcrc_idx_err", bus.index_error, 0);
    check("badcrc_payload", bus.resp_payload, 32'h000001AA);
    tick();

    // CMD8 reply with index 9 and matching CRC
    send_cmd(6'd8, 32'h000001AA, 1'b1, fr, oe_bad);
    r = {2'b00, 6'd9, 32'h000001AA, crc7({2'b00, 6'd9, 32'h000001AA}), 1'b1};
    reply(r);
    wait_complete(n);
    check("badidx_idx_err", bus.index_error, 1);
    check("badidx_crc", bus.crc_error, 0);
    check("badidx_resp_index", bus.resp_index, 9);
    tick();

    // CMD17, line held high: timeout
    send_cmd(6'd17, 32'h0, 1'b1, fr, oe_bad);
    wait_complete(n);
    check("to_strobes", n, 64);
    check("to_flag", bus.timeout_error, 1);
    check("to_other_errs", {bus.crc_error, bus.index_error}, 0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (bus.cmd_complete) pulses++; end
    check("to_single_complete", pulses, 0);

    // CMD0 with strobe every 4th cycle, ignored new_command, reset at bit 20
    div = 4;
    bus.new_command   = 1'b1;
    bus.cmd_index     = 6'd0;
    bus.cmd_argument  = 32'h0;
    bus.resp_expected = 1'b0;
    tick();
    bus.new_command = 1'b0;
    check("slow_errs_cleared", bus.timeout_error, 0);
    got = '0; bits = 0; hold = 0; hold_bad = 0; guard = 0;
    while (bits < 20 && guard < 400) begin
      hold++;
      if (bus.bit_strobe) begin
        got = {got[18:0], bus.CMD_PIN_OUT};
        if (bits > 0 && hold != 4) hold_bad++;
        bits++;
        hold = 0;
        if (bits == 10) begin
          bus.new_command = 1'b1;
          bus.cmd_index   = 6'd5;
        end
      end
      tick();
      bus.new_command = 1'b0;
      guard++;
    end
    check("slow_bits_seen", bits, 20);
    check("slow_prefix", got, 20'h40000);
    check("slow_hold4", hold_bad, 0);
    check("slow_busy", bus.busy, 1);
    reset_host = 1'b1;
    tick();
    reset_host = 1'b0;
    check("rst_mid_oe", bus.io_enable_cmd, 0);
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_pin", bus.CMD_PIN_OUT, 1);
    pulses = 0;
    for (int i = 0; i < 120; i++) begin
      if (bus.cmd_complete) pulses++;
      tick();
    end
    check("rst_mid_no_complete", pulses, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
